// File: rtl/elink_dec8b10b_in2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// elink_dec8b10b_in2 : 2-bit e-link deserialiser, K28.5 aligner, 8b10b decoder
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
module elink_dec8b10b_in2 (
  input  logic       bitCLK,
  input  logic       rst,
  input  logic [1:0] DATA_IN,
  input  logic       swap_inputbits,
  input  logic       thCR_REVERSE_10B,
  output logic [7:0] HGFEDCBA,
  output logic [1:0] ISK,
  output logic [9:0] DATA_OUT_dbg,
  output logic       DATA_RDY
);

  localparam logic [9:0] COMMA_RDN  = 10'b0011111010;
  localparam logic [9:0] COMMA_RDP  = 10'b1100000101;
  localparam logic [2:0] LAST_PHASE = 3'd4;

  logic [9:0] sreg_q, sreg_d;
  logic       aligned_q, aligned_d;
  logic [2:0] phase_q, phase_d;
  logic [7:0] byte_q, byte_d;
  logic [1:0] isk_q, isk_d;
  logic [9:0] dbg_q, dbg_d;
  logic       rdy_q, rdy_d;

  logic [1:0] din;
  logic [9:0] cw;
  logic       comma;
  logic       capture;
  logic [2:0] phase_eff;
  logic [4:0] edcba;
  logic       v6, k28;
  logic [2:0] hgf;
  logic       v4;
  logic [3:0] fghj_k;
  logic       k_alt;
  logic [7:0] sym_byte;
  logic [1:0] sym_isk;

  // Comma search runs on the word after optional reversal so that a
  // reverse-mode encoder pairs with thCR_REVERSE_10B=1.
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      cw[i] = thCR_REVERSE_10B ? sreg_q[9-i] : sreg_q[i];
    end
    comma = (cw == COMMA_RDN) || (cw == COMMA_RDP);
  end

  always_comb begin
    v6    = 1'b1;
    k28   = 1'b0;
    edcba = 5'd0;
    case (cw[9:4])
      6'b100111, 6'b011000: edcba = 5'd0;
      6'b011101, 6'b100010: edcba = 5'd1;
      6'b101101, 6'b010010: edcba = 5'd2;
      6'b110001:            edcba = 5'd3;
      6'b110101, 6'b001010: edcba = 5'd4;
      6'b101001:            edcba = 5'd5;
      6'b011001:            edcba = 5'd6;
      6'b111000, 6'b000111: edcba = 5'd7;
      6'b111001, 6'b000110: edcba = 5'd8;
      6'b100101:            edcba = 5'd9;
      6'b010101:            edcba = 5'd10;
      6'b110100:            edcba = 5'd11;
      6'b001101:            edcba = 5'd12;
      6'b101100:            edcba = 5'd13;
      6'b011100:            edcba = 5'd14;
      6'b010111, 6'b101000: edcba = 5'd15;
      6'b011011, 6'b100100: edcba = 5'd16;
      6'b100011:            edcba = 5'd17;
      6'b010011:            edcba = 5'd18;
      6'b110010:            edcba = 5'd19;
      6'b001011:            edcba = 5'd20;
      6'b101010:            edcba = 5'd21;
      6'b011010:            edcba = 5'd22;
      6'b111010, 6'b000101: edcba = 5'd23;
      6'b110011, 6'b001100: edcba = 5'd24;
      6'b100110:            edcba = 5'd25;
      6'b010110:            edcba = 5'd26;
      6'b110110, 6'b001001: edcba = 5'd27;
      6'b001110:            edcba = 5'd28;
      6'b101110, 6'b010001: edcba = 5'd29;
      6'b011110, 6'b100001: edcba = 5'd30;
      6'b101011, 6'b010100: edcba = 5'd31;
      6'b001111, 6'b110000: begin
        edcba = 5'd28;
        k28   = 1'b1;
      end
      default: v6 = 1'b0;
    endcase
  end

  // K28 4b codes of the positive-disparity 6b form are the complements of
  // the negative form, so fold them onto one table.
  always_comb begin
    v4     = 1'b1;
    hgf    = 3'd0;
    fghj_k = (cw[9:4] == 6'b110000) ? ~cw[3:0] : cw[3:0];
    if (k28) begin
      case (fghj_k)
        4'b0100: hgf = 3'd0;
        4'b1001: hgf = 3'd1;
        4'b0101: hgf = 3'd2;
        4'b0011: hgf = 3'd3;
        4'b0010: hgf = 3'd4;
        4'b1010: hgf = 3'd5;
        4'b0110: hgf = 3'd6;
        4'b1000: hgf = 3'd7;
        default: v4 = 1'b0;
      endcase
    end else begin
      case (cw[3:0])
        4'b1011, 4'b0100:                   hgf = 3'd0;
        4'b1001:                            hgf = 3'd1;
        4'b0101:                            hgf = 3'd2;
        4'b1100, 4'b0011:                   hgf = 3'd3;
        4'b1101, 4'b0010:                   hgf = 3'd4;
        4'b1010:                            hgf = 3'd5;
        4'b0110:                            hgf = 3'd6;
        4'b1110, 4'b0001, 4'b0111, 4'b1000: hgf = 3'd7;
        default:                            v4 = 1'b0;
      endcase
    end
  end

  always_comb begin
    k_alt = !k28 && ((edcba == 5'd23) || (edcba == 5'd27) || (edcba == 5'd29) ||
                     (edcba == 5'd30)) && ((cw[3:0] == 4'b0111) || (cw[3:0] == 4'b1000));
    sym_byte = 8'h00;
    sym_isk  = 2'b00;
    if (v6 && v4) begin
      sym_byte = {hgf, edcba};
      if (k28) begin
        case (hgf)
          3'd1:    sym_isk = 2'b10;
          3'd6:    sym_isk = 2'b01;
          default: sym_isk = 2'b11;
        endcase
      end else if (k_alt) begin
        sym_isk = 2'b11;
      end
    end
  end

  always_comb begin
    din       = swap_inputbits ? {DATA_IN[0], DATA_IN[1]} : DATA_IN;
    sreg_d    = {sreg_q[7:0], din};
    capture   = comma || (aligned_q && (phase_q == 3'd0));
    phase_eff = comma ? 3'd0 : phase_q;
    phase_d   = (phase_eff == LAST_PHASE) ? 3'd0 : phase_eff + 3'd1;
    aligned_d = aligned_q || comma;
    byte_d    = byte_q;
    isk_d     = isk_q;
    dbg_d     = dbg_q;
    rdy_d     = capture;
    if (capture) begin
      byte_d = sym_byte;
      isk_d  = sym_isk;
      dbg_d  = cw;
    end
  end

  always_ff @(posedge bitCLK) begin
    if (rst) begin
      sreg_q    <= 10'd0;
      aligned_q <= 1'b0;
      phase_q   <= 3'd0;
      byte_q    <= 8'h00;
      isk_q     <= 2'b00;
      dbg_q     <= 10'd0;
      rdy_q     <= 1'b0;
    end else begin
      sreg_q    <= sreg_d;
      aligned_q <= aligned_d;
      phase_q   <= phase_d;
      byte_q    <= byte_d;
      isk_q     <= isk_d;
      dbg_q     <= dbg_d;
      rdy_q     <= rdy_d;
    end
  end

  assign HGFEDCBA     = byte_q;
  assign ISK          = isk_q;
  assign DATA_OUT_dbg = dbg_q;
  assign DATA_RDY     = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_elink_dec8b10b_in2.sv
`default_nettype none
// Bench for elink_dec8b10b_in2: bit-level stream model plus code-table
// lookup built from the 8b10b encoder tables, checked by a negedge monitor.
module tb_elink_dec8b10b_in2;

  logic       bitCLK = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] DATA_IN = 2'b00;
  logic       swap_inputbits = 1'b0;
  logic       thCR_REVERSE_10B = 1'b0;
  logic [7:0] HGFEDCBA;
  logic [1:0] ISK;
  logic [9:0] DATA_OUT_dbg;
  logic       DATA_RDY;

  elink_dec8b10b_in2 dut (
    .bitCLK           (bitCLK),
    .rst              (rst),
    .DATA_IN          (DATA_IN),
    .swap_inputbits   (swap_inputbits),
    .thCR_REVERSE_10B (thCR_REVERSE_10B),
    .HGFEDCBA         (HGFEDCBA),
    .ISK              (ISK),
    .DATA_OUT_dbg     (DATA_OUT_dbg),
    .DATA_RDY         (DATA_RDY)
  );

  always #12 bitCLK = ~bitCLK;

  localparam logic [9:0] K285N = 10'b0011111010;
  localparam logic [9:0] K285P = 10'b1100000101;
  localparam logic [9:0] K281N = 10'b0011111001;
  localparam logic [9:0] D00N  = 10'b1001110100;
  localparam logic [9:0] K286N = 10'b0011110110;

  localparam bit [5:0] T6N [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam bit [5:0] T6P [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam bit [3:0] T4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam bit [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  localparam bit [3:0] K4N [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  localparam bit [3:0] K4P [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  localparam int KX7 [4] = '{23, 27, 29, 30};

  typedef struct {
    int         cyc;
    logic [7:0] b;
    logic [1:0] k;
    logic [9:0] dbg;
  } exp_t;

  bit [9:0] dec_map [bit [9:0]];  // code -> {isk, byte}
  exp_t     expq[$];
  bit       hist[$];
  bit       m_aligned;
  int       m_cnt;
  bit       enc_rev = 1'b0;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   strobes = 0;
  logic rst_at_edge = 1'b1;
  exp_t mon_e;
  exp_t last_e = '{0, 8'h00, 2'b00, 10'd0};

  always @(posedge bitCLK) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [9:0] rev10(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  // Every encoder output for either running disparity maps back to its byte.
  function automatic void build_tables();
    bit [5:0] s6;
    bit [1:0] isk;
    for (int x = 0; x < 32; x++) begin
      for (int p = 0; p < 2; p++) begin
        s6 = (p != 0) ? T6P[x] : T6N[x];
        for (int y = 0; y < 8; y++) begin
          dec_map[{s6, T4N[y]}] = {2'b00, 3'(y), 5'(x)};
          dec_map[{s6, T4P[y]}] = {2'b00, 3'(y), 5'(x)};
        end
        dec_map[{s6, 4'b0111}] = {2'b00, 3'd7, 5'(x)};
        dec_map[{s6, 4'b1000}] = {2'b00, 3'd7, 5'(x)};
      end
    end
    for (int y = 0; y < 8; y++) begin
      isk = (y == 1) ? 2'b10 : (y == 6) ? 2'b01 : 2'b11;
      dec_map[{6'b001111, K4N[y]}] = {isk, 3'(y), 5'd28};
      dec_map[{6'b110000, K4P[y]}] = {isk, 3'(y), 5'd28};
    end
    // K23.7, K27.7, K29.7, K30.7 reuse the data 6b codes with the alternate 7 form.
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 2; p++) begin
        s6 = (p != 0) ? T6P[KX7[i]] : T6N[KX7[i]];
        dec_map[{s6, 4'b0111}] = {2'b11, 3'd7, 5'(KX7[i])};
        dec_map[{s6, 4'b1000}] = {2'b11, 3'd7, 5'(KX7[i])};
      end
    end
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 10; i++) hist.push_back(1'b0);
    m_aligned = 1'b0;
    m_cnt     = 0;
    for (int i = expq.size() - 1; i >= 0; i--) begin
      if (expq[i].cyc >= cyc + 1) expq.delete(i);
    end
  endtask

  // Called at the negedge before the edge that shifts (e,l) in; a word
  // completed by this pair is expected on the monitor two edges later.
  task automatic model_feed(input bit e, input bit l);
    logic [9:0] w;
    logic [9:0] cw;
    exp_t       x;
    hist.push_back(e);
    hist.push_back(l);
    while (hist.size() > 10) void'(hist.pop_front());
    for (int i = 0; i < 10; i++) w[9-i] = hist[i];
    cw = thCR_REVERSE_10B ? rev10(w) : w;
    m_cnt++;
    if (cw == K285N || cw == K285P) begin
      m_aligned = 1'b1;
      m_cnt     = 5;
    end
    if (m_aligned && m_cnt == 5) begin
      m_cnt = 0;
      x.cyc = cyc + 2;
      x.dbg = cw;
      if (dec_map.exists(cw)) {x.k, x.b} = dec_map[cw];
      else {x.k, x.b} = 10'd0;
      expq.push_back(x);
    end
  endtask

  task automatic send_pair(input bit e, input bit l);
    @(negedge bitCLK);
    DATA_IN = swap_inputbits ? {l, e} : {e, l};
    model_feed(e, l);
  endtask

  task automatic send_word(input logic [9:0] w);
    logic [9:0] t;
    t = enc_rev ? rev10(w) : w;
    for (int i = 0; i < 5; i++) send_pair(t[9-2*i], t[8-2*i]);
  endtask

  task automatic do_reset(input int n, input bit swp, input bit rv, input bit er);
    @(negedge bitCLK);
    rst     = 1'b1;
    DATA_IN = 2'b00;
    model_reset();
    swap_inputbits   = swp;
    thCR_REVERSE_10B = rv;
    enc_rev          = er;
    repeat (n - 1) @(negedge bitCLK);
    @(negedge bitCLK);
    rst = 1'b0;
    model_feed(1'b0, 1'b0);
  endtask

  function automatic logic [9:0] rand_word();
    int       r;
    int       x;
    int       y;
    bit       p;
    logic [5:0] s6;
    logic [3:0] s4;
    r = $urandom_range(0, 11);
    x = $urandom_range(0, 255);
    y = x / 32;
    p = 1'($urandom_range(0, 1));
    if (r == 0) return p ? K285P : K285N;
    if (r == 1) return 10'($urandom);
    if (r == 2) return p ? {6'b110000, K4P[y]} : {6'b001111, K4N[y]};
    s6 = p ? T6P[x % 32] : T6N[x % 32];
    if (y == 7 && $urandom_range(0, 1) == 1) s4 = ($urandom_range(0, 1) == 1) ? 4'b0111 : 4'b1000;
    else s4 = ($urandom_range(0, 1) == 1) ? T4P[y] : T4N[y];
    return {s6, s4};
  endfunction

  always @(negedge bitCLK) begin
    if (rst_at_edge) begin
      check("rst_byte", 32'(HGFEDCBA), 32'h0);
      check("rst_isk", 32'(ISK), 32'h0);
      check("rst_dbg", 32'(DATA_OUT_dbg), 32'h0);
      check("rst_rdy", 32'(DATA_RDY), 32'h0);
      last_e = '{0, 8'h00, 2'b00, 10'd0};
    end else if (expq.size() > 0 && expq[0].cyc == cyc) begin
      mon_e = expq.pop_front();
      check("strobe", 32'(DATA_RDY), 32'h1);
      check("byte", 32'(HGFEDCBA), 32'(mon_e.b));
      check("isk", 32'(ISK), 32'(mon_e.k));
      check("dbg", 32'(DATA_OUT_dbg), 32'(mon_e.dbg));
      last_e = mon_e;
    end else begin
      check("no_strobe", 32'(DATA_RDY), 32'h0);
      check("hold_byte", 32'(HGFEDCBA), 32'(last_e.b));
      check("hold_isk", 32'(ISK), 32'(last_e.k));
      check("hold_dbg", 32'(DATA_OUT_dbg), 32'(last_e.dbg));
    end
    if (DATA_RDY) strobes++;
  end

  initial begin
    int s0;
    build_tables();
    model_reset();

    // Commas with a one-pair offset, then the SOP/data/EOP trio and random traffic.
    do_reset(3, 1'b0, 1'b0, 1'b0);
    repeat (8) send_word(K285N);
    send_word(K281N);
    send_word(D00N);
    send_word(K286N);
    send_word(K285P);
    repeat (150) send_word(rand_word());
    send_word(K285N);
    send_word(10'b0000000000);
    send_word(K285N);
    send_word(K285P);

    // Phase slips: one extra pair, then one pair short.
    repeat (3) send_word(K285N);
    send_pair(1'b1, 1'b0);
    repeat (3) send_word(K285N);
    for (int i = 0; i < 4; i++) send_pair(K285N[9-2*i], K285N[8-2*i]);
    repeat (3) send_word(D00N);
    send_word(K285N);

    // Reset in the middle of a word; data before the next comma is ignored.
    send_pair(1'b0, 1'b0);
    send_pair(1'b1, 1'b1);
    do_reset(2, 1'b0, 1'b0, 1'b0);
    send_word(D00N);
    send_word(K281N);
    send_word(K285N);
    send_word(K286N);

    // Reversed transmit with matching receive reversal.
    do_reset(2, 1'b0, 1'b1, 1'b1);
    repeat (3) send_word(K285N);
    send_word(K281N);
    send_word(D00N);
    send_word(K286N);
    repeat (40) send_word(rand_word());

    // Reversed transmit without receive reversal: no comma, no strobe.
    do_reset(2, 1'b0, 1'b0, 1'b1);
    s0 = strobes;
    repeat (6) send_word(K285N);

    // Swapped bit pairs.
    do_reset(2, 1'b1, 1'b0, 1'b0);
    check("mismatch_strobes", 32'(strobes - s0), 32'h0);
    repeat (3) send_word(K285N);
    send_word(K281N);
    send_word(D00N);
    send_word(K286N);
    repeat (60) send_word(rand_word());

    @(negedge bitCLK);
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge bitCLK);
    check("drain", 32'(expq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
